// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: one requester port (request, write data, grant, read return) of the data-memory arbiter
interface dmem_port_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;
  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares one data memory between CPU (m0) and aux master (m1), fixed-latency tagged read return
// Define DMEM_ARB_FIXED_PRIO_EN for fixed M0 priority; default build is round-robin.
module dmem_port_arbiter #(
  parameter int AW     = 8,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clock,
  input  logic          reset,
  dmem_port_arbiter_if.slave m0,
  dmem_port_arbiter_if.slave m1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  logic              g0, g1;
  logic [RD_LAT:0]   vld_q, id_q;
  logic [DW-1:0]     rdata0_q, rdata1_q;
`ifdef DMEM_ARB_FIXED_PRIO_EN
  always_comb begin
    g0 = ~reset & m0.req;
    g1 = ~reset & m1.req & ~m0.req;
  end
`else
  logic rr_q, rr_d;
  // rr_q = 1 when M1 was granted last; reset makes M1 win the first tie
  always_comb begin
    g0   = ~reset & m0.req & (~m1.req | rr_q);
    g1   = ~reset & m1.req & (~m0.req | ~rr_q);
    rr_d = (g0 | g1) ? g1 : rr_q;
  end
  always_ff @(posedge clock) rr_q <= reset ? 1'b0 : rr_d;
`endif
  always_comb begin
    mem_en    = g0 | g1;
    mem_we    = g0 ? m0.we : g1 ? m1.we : 1'b0;
    mem_addr  = g0 ? m0.addr : g1 ? m1.addr : '0;
    mem_wdata = g0 ? m0.wdata : g1 ? m1.wdata : '0;
  end
  // stage RD_LAT-1 is visible while memory presents data; stage RD_LAT drives rvalid
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q    <= '0;
      id_q     <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      vld_q <= {vld_q[RD_LAT-1:0], mem_en & ~mem_we};
      id_q  <= {id_q[RD_LAT-1:0], g1};
      if (vld_q[RD_LAT-1] & ~id_q[RD_LAT-1]) rdata0_q <= mem_rdata;
      if (vld_q[RD_LAT-1] & id_q[RD_LAT-1]) rdata1_q <= mem_rdata;
    end
  end
  assign m0.gnt    = g0;
  assign m1.gnt    = g1;
  assign m0.rvalid = vld_q[RD_LAT] & ~id_q[RD_LAT];
  assign m1.rvalid = vld_q[RD_LAT] & id_q[RD_LAT];
  assign m0.rdata  = rdata0_q;
  assign m1.rdata  = rdata1_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: two arbiters (RD_LAT 1 and 3) with memory models and a read-return scoreboard
module tb_dmem_port_arbiter;
  localparam int AW = 8, DW = 32;
  typedef struct {logic id; logic [DW-1:0] d; int c;} exp_t;
  logic clk = 0, reset = 1;
  int checks = 0, errors = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  dmem_port_arbiter_if #(AW, DW) p0[2] ();
  dmem_port_arbiter_if #(AW, DW) p1[2] ();

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int L = g ? 3 : 1;
    logic mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [DW-1:0] mem [256];
    logic [255:0] wr_v = '0;
    logic [DW-1:0] rpipe [L];
    logic [DW-1:0] rm [256];
    logic [255:0] rm_v = '0;
    exp_t q[$];
    exp_t e;
    int rvc[2] = '{0, 0};
    logic [1:0] gv, wv, rvv;
    logic [AW-1:0] av [2];
    logic [DW-1:0] wdv [2], rdv [2];
    assign gv = {p1[g].gnt, p0[g].gnt};
    assign wv = {p1[g].we, p0[g].we};
    assign rvv = {p1[g].rvalid, p0[g].rvalid};
    assign av[0] = p0[g].addr;
    assign av[1] = p1[g].addr;
    assign wdv[0] = p0[g].wdata;
    assign wdv[1] = p1[g].wdata;
    assign rdv[0] = p0[g].rdata;
    assign rdv[1] = p1[g].rdata;
    dmem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(L)) dut (
      .clock(clk), .reset(reset), .m0(p0[g]), .m1(p1[g]),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));
    always @(posedge clk) begin
      if (mem_en && mem_we) begin
        mem[mem_addr] <= mem_wdata;
        wr_v[mem_addr] <= 1'b1;
      end
      rpipe[0] <= wr_v[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
      for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[L-1];
    always @(negedge clk) begin
      if (reset) q.delete();
      else begin
        checks++;
        if (mem_en !== (gv[0] | gv[1]) || (gv[0] & gv[1]) || (!mem_en && (mem_addr !== '0 || mem_we !== 1'b0))) begin
          errors++;
          $display("FAIL grant_excl[%0d] cyc %0d: mem_en=%b gnt=%b addr=%h", g, cyc, mem_en, gv, mem_addr);
        end
        for (int m = 0; m < 2; m++) begin
          if (rvv[m]) begin
            checks++;
            rvc[m]++;
            if (q.size() == 0) begin
              errors++;
              $display("FAIL rvalid_spurious[%0d] m%0d cyc %0d: rvalid=1 required 0", g, m, cyc);
            end else begin
              e = q.pop_front();
              if (e.id !== 1'(m) || e.d !== rdv[m] || e.c != cyc) begin
                errors++;
                $display("FAIL rdata_return[%0d] m%0d cyc %0d: data=%h required m%0d data=%h cyc %0d", g, m, cyc, rdv[m], e.id, e.d, e.c);
              end
            end
          end
          if (gv[m]) begin
            checks++;
            if (mem_addr !== av[m] || mem_we !== wv[m] || (wv[m] && mem_wdata !== wdv[m])) begin
              errors++;
              $display("FAIL mem_mux[%0d] m%0d: we=%b addr=%h wdata=%h required we=%b addr=%h wdata=%h", g, m, mem_we, mem_addr, mem_wdata, wv[m], av[m], wdv[m]);
            end
            if (wv[m]) begin
              rm[av[m]] = wdv[m];
              rm_v[av[m]] = 1'b1;
            end else q.push_back('{1'(m), rm_v[av[m]] ? rm[av[m]] : init_val(av[m]), cyc + L + 1});
          end
        end
        if (q.size() != 0 && q[0].c < cyc) begin
          checks++;
          errors++;
          e = q.pop_front();
          $display("FAIL rvalid_missing[%0d] m%0d: no rvalid at cyc %0d required", g, e.id, e.c);
        end
      end
    end
  end

  task automatic drive(input int k, input int m, input logic r, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (k == 0 && m == 0) begin p0[0].req = r; p0[0].we = w; p0[0].addr = a; p0[0].wdata = d; end
    else if (k == 0) begin p1[0].req = r; p1[0].we = w; p1[0].addr = a; p1[0].wdata = d; end
    else if (m == 0) begin p0[1].req = r; p0[1].we = w; p0[1].addr = a; p0[1].wdata = d; end
    else begin p1[1].req = r; p1[1].we = w; p1[1].addr = a; p1[1].wdata = d; end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 2; k++) for (int m = 0; m < 2; m++) drive(k, m, 0, 0, '0, '0);
  endtask

  task automatic test_reset();
    logic e1;
    reset = 1;
    drive(0, 0, 1, 0, 8'h05, '0); drive(0, 1, 1, 0, 8'h06, '0);
    drive(1, 0, 1, 0, 8'h07, '0); drive(1, 1, 1, 0, 8'h08, '0);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({p0[0].gnt, p1[0].gnt, u[0].mem_en, u[0].mem_we, p0[0].rvalid, p1[0].rvalid} !== 6'b0 ||
          p0[0].rdata !== '0 || p1[0].rdata !== '0 || u[0].mem_addr !== '0 || u[0].mem_wdata !== '0) begin
        errors++;
        $display("FAIL reset_outputs: gnt=%b%b mem_en=%b rvalid=%b%b rdata=%h/%h required all 0",
                 p0[0].gnt, p1[0].gnt, u[0].mem_en, p0[0].rvalid, p1[0].rvalid, p0[0].rdata, p1[0].rdata);
      end
      checks++;
      if ({p0[1].gnt, p1[1].gnt, u[1].mem_en} !== 3'b0) begin
        errors++;
        $display("FAIL reset_outputs_lat3: gnt=%b%b mem_en=%b required 000", p0[1].gnt, p1[1].gnt, u[1].mem_en);
      end
    end
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
`ifdef DMEM_ARB_FIXED_PRIO_EN
    e1 = 1'b0;
`else
    e1 = 1'b1;
`endif
    checks++;
    if (p1[0].gnt !== e1 || p0[0].gnt !== ~e1 || p1[1].gnt !== e1 || p0[1].gnt !== ~e1) begin
      errors++;
      $display("FAIL first_tie: m0_gnt=%b m1_gnt=%b (lat3 %b %b) required m0=%b m1=%b",
               p0[0].gnt, p1[0].gnt, p0[1].gnt, p1[1].gnt, ~e1, e1);
    end
    tick();
    idle_all();
    repeat (6) tick();
  endtask

  task automatic test_raw();
    int r1;
    r1 = u[0].rvc[1];
    drive(0, 0, 1, 1, 8'h10, 32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if (p0[0].gnt !== 1'b1 || u[0].mem_we !== 1'b1) begin
      errors++;
      $display("FAIL raw_write_gnt: gnt=%b mem_we=%b required 1 1", p0[0].gnt, u[0].mem_we);
    end
    tick();
    drive(0, 0, 1, 0, 8'h10, '0);
    @(negedge clk);
    checks++;
    if (p0[0].gnt !== 1'b1 || p0[0].rvalid !== 1'b0) begin
      errors++;
      $display("FAIL raw_read_gnt: gnt=%b rvalid=%b required 1 0", p0[0].gnt, p0[0].rvalid);
    end
    tick();
    drive(0, 0, 0, 0, '0, '0);
    @(negedge clk);
    checks++;
    if (p0[0].rvalid !== 1'b0) begin
      errors++;
      $display("FAIL raw_early_rvalid: rvalid=%b required 0 at G+1", p0[0].rvalid);
    end
    @(negedge clk);
    checks++;
    if (p0[0].rvalid !== 1'b1 || p0[0].rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL raw_return: rvalid=%b rdata=%h required 1 deadbeef at G+2", p0[0].rvalid, p0[0].rdata);
    end
    @(negedge clk);
    checks++;
    if (p0[0].rvalid !== 1'b0 || p0[0].rdata !== 32'hDEADBEEF || u[0].rvc[1] != r1) begin
      errors++;
      $display("FAIL raw_hold: rvalid=%b rdata=%h m1_pulses=%0d required 0 deadbeef %0d", p0[0].rvalid, p0[0].rdata, u[0].rvc[1], r1);
    end
    tick();
  endtask

  task automatic test_rr_alternate();
    int n0 = 0, n1 = 0, r0, r1, x0, x1;
    logic e1;
    r0 = u[0].rvc[0];
    r1 = u[0].rvc[1];
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 1, 0, 8'h40 + 8'(n0), '0);
      drive(0, 1, 1, 0, 8'h80 + 8'(n1), '0);
      @(negedge clk);
`ifdef DMEM_ARB_FIXED_PRIO_EN
      e1 = 1'b0;
`else
      e1 = (i % 2 == 0);
`endif
      checks++;
      if (p1[0].gnt !== e1 || p0[0].gnt !== ~e1) begin
        errors++;
        $display("FAIL rr_alternate[%0d]: m0_gnt=%b m1_gnt=%b required %b %b", i, p0[0].gnt, p1[0].gnt, ~e1, e1);
      end
      if (p0[0].gnt) n0++;
      if (p1[0].gnt) n1++;
      tick();
    end
    idle_all();
    repeat (5) tick();
`ifdef DMEM_ARB_FIXED_PRIO_EN
    x0 = 6; x1 = 0;
`else
    x0 = 3; x1 = 3;
`endif
    checks++;
    if (u[0].rvc[0] - r0 != x0 || u[0].rvc[1] - r1 != x1) begin
      errors++;
      $display("FAIL rr_pulse_count: m0=%0d m1=%0d required %0d %0d", u[0].rvc[0] - r0, u[0].rvc[1] - r1, x0, x1);
    end
  endtask

  task automatic test_lat3();
    int g = 0, dt;
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 1, 0, 8'(i), '0);
      @(negedge clk);
      checks++;
      if (p0[1].gnt !== 1'b1 || p1[1].gnt !== 1'b0) begin
        errors++;
        $display("FAIL lat3_gnt[%0d]: gnt=%b required 1", i, p0[1].gnt);
      end
      if (i == 1) g = cyc;
      tick();
    end
    drive(1, 0, 0, 0, '0, '0);
    repeat (6) begin
      @(negedge clk);
      dt = cyc - g;
      checks++;
      if (p0[1].rvalid !== (dt >= 4 && dt <= 6) || (dt >= 4 && dt <= 6 && p0[1].rdata !== init_val(8'(dt - 3)))) begin
        errors++;
        $display("FAIL lat3_return G+%0d: rvalid=%b rdata=%h required %b %h", dt, p0[1].rvalid, p0[1].rdata,
                 (dt >= 4 && dt <= 6), init_val(8'(dt - 3)));
      end
    end
    tick();
  endtask

  task automatic test_reset_flush();
    int r0;
    drive(0, 0, 1, 0, 8'h20, '0);
    @(negedge clk);
    checks++;
    if (p0[0].gnt !== 1'b1) begin
      errors++;
      $display("FAIL flush_gnt: gnt=%b required 1", p0[0].gnt);
    end
    r0 = u[0].rvc[0];
    tick();
    drive(0, 0, 0, 0, '0, '0);
    reset = 1;
    tick();
    reset = 0;
    repeat (5) @(negedge clk);
    checks++;
    if (u[0].rvc[0] != r0 || p0[0].rdata !== '0 || p1[0].rdata !== '0) begin
      errors++;
      $display("FAIL flush_drop: pulses=%0d rdata=%h/%h required %0d 0/0", u[0].rvc[0], p0[0].rdata, p1[0].rdata, r0);
    end
    tick();
  endtask

  task automatic test_prio();
    logic e1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0, 8'h30, '0);
      drive(0, 1, 1, 0, 8'h31, '0);
      @(negedge clk);
`ifdef DMEM_ARB_FIXED_PRIO_EN
      e1 = 1'b0;
`else
      e1 = (i % 2 == 0);
`endif
      checks++;
      if (p1[0].gnt !== e1 || p0[0].gnt !== ~e1) begin
        errors++;
        $display("FAIL prio[%0d]: m0_gnt=%b m1_gnt=%b required %b %b", i, p0[0].gnt, p1[0].gnt, ~e1, e1);
      end
      tick();
    end
    drive(0, 0, 0, 0, '0, '0);
    @(negedge clk);
    checks++;
    if (p1[0].gnt !== 1'b1 || p0[0].gnt !== 1'b0) begin
      errors++;
      $display("FAIL prio_m0_drop: m0_gnt=%b m1_gnt=%b required 0 1", p0[0].gnt, p1[0].gnt);
    end
    tick();
    idle_all();
    repeat (6) tick();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_raw();
    test_rr_alternate();
    test_lat3();
    test_reset_flush();
    test_prio();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
